// File: rtl/ctrl_pkg.sv
// Shared control definitions for the ID-stage controller: opcodes, ALU-op
// encodings, the ID/EX control bundle and the sequencer state type.
package ctrl_pkg;

  localparam logic [7:0] OP_ADD  = 8'h08;
  localparam logic [7:0] OP_MUL  = 8'h18;
  localparam logic [7:0] OP_ADDI = 8'h03;
  localparam logic [7:0] OP_SW   = 8'h19;
  localparam logic [7:0] OP_LW   = 8'h31;
  localparam logic [7:0] OP_JAL  = 8'h04;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_MUL = 4'b0010;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_IMM = 2'b01;

  localparam logic [1:0] WB_SEL0 = 2'b00;
  localparam logic [1:0] WB_SEL1 = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  typedef struct packed {
    logic [1:0] alu_src;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle plus rs2-use, MUL and JAL flags.
// Unknown opcodes decode to an all-zero NOP.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 8
) (
  input  logic [OP_W-1:0] op,
  output ctrl_bundle_t    ctrl,
  output logic            uses_rs2,
  output logic            is_mul,
  output logic            is_jal
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    ctrl     = CTRL_NOP;
    uses_rs2 = 1'b0;
    is_mul   = 1'b0;
    is_jal   = 1'b0;
    case (op)
      OP_W'(OP_ADD): begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.reg_write = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_W'(OP_MUL): begin
        ctrl.alu_op    = ALU_MUL;
        ctrl.reg_write = 1'b1;
        uses_rs2       = 1'b1;
        is_mul         = 1'b1;
      end
      OP_W'(OP_ADDI): begin
        ctrl.alu_src    = SRC_IMM;
        ctrl.mem_to_reg = WB_SEL1;
        ctrl.reg_write  = 1'b1;
      end
      OP_W'(OP_SW): begin
        ctrl.alu_src   = SRC_IMM;
        ctrl.mem_write = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_W'(OP_LW): begin
        ctrl.alu_src    = SRC_IMM;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = WB_SEL1;
        ctrl.reg_write  = 1'b1;
      end
      OP_W'(OP_JAL): begin
        ctrl.mem_to_reg = WB_LINK;
        ctrl.reg_write  = 1'b1;
        is_jal          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID-stage controller: decode, ID/EX control register, load-use and MUL stall
// sequencing, JAL redirect. Define CTRL_PERF_EN to build the stall counter.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 8,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  output logic              stall,
  output logic              pc_src,
  output logic              flush_if,
  output logic              ex_hold,
  output logic [1:0]        ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [1:0]        ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  ctrl_bundle_t      dec_ctrl;
  logic              dec_rs2;
  logic              dec_mul;
  logic              dec_jal;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  ctrl_bundle_t      ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_load;
  logic              stall_c, hold_c, jump_c;
  logic              load_use;

  ctrl_decode #(.OP_W(OP_W)) u_decode (
    .op       (id_op),
    .ctrl     (dec_ctrl),
    .uses_rs2 (dec_rs2),
    .is_mul   (dec_mul),
    .is_jal   (dec_jal)
  );

  assign load_use = ex_ctrl_q.mem_read && (ex_rd_q != '0) &&
                    ((ex_rd_q == id_rs1) || (dec_rs2 && (ex_rd_q == id_rs2)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ex_load   = 1'b1;
    ex_ctrl_d = CTRL_NOP;
    ex_rd_d   = '0;
    stall_c   = 1'b0;
    hold_c    = 1'b0;
    jump_c    = 1'b0;
    case (state_q)
      MUL_BUSY: begin
        stall_c = 1'b1;
        hold_c  = 1'b1;
        ex_load = 1'b0;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = IDLE;
      end
      default: begin
        // A load-use stall leaves ex_*_d at the bubble default.
        if (load_use) begin
          stall_c = 1'b1;
        end else if (id_valid) begin
          ex_ctrl_d = dec_ctrl;
          ex_rd_d   = dec_ctrl.reg_write ? id_rd : '0;
          jump_c    = dec_jal;
          if (dec_mul && (MUL_LAT > 1)) begin
            state_d = MUL_BUSY;
            cnt_d   = CW'(MUL_LAT - 1);
          end
        end
      end
    endcase
  end

  // Front-end controls are forced low while reset is held so nothing redirects
  // or stalls the fetch during reset.
  assign stall    = stall_c & ~rst;
  assign ex_hold  = hold_c  & ~rst;
  assign pc_src   = jump_c  & ~rst;
  assign flush_if = jump_c  & ~rst;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ex_ctrl_q <= CTRL_NOP;
      ex_rd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ex_load) begin
        ex_ctrl_q <= ex_ctrl_d;
        ex_rd_q   <= ex_rd_d;
      end
    end
  end

  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_alu_op     = ex_ctrl_q.alu_op;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_mem_write  = ex_ctrl_q.mem_write;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign ex_reg_write  = ex_ctrl_q.reg_write;
  assign ex_rd         = ex_rd_q;

`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Parametrised successor to the single-cycle opcode decoder. Decodes the ID-stage opcode into the control bundle and registers it into the ID/EX pipeline stage. Detects load-use hazards and sequences multi-cycle MUL with a latency counter, driving stall, bubble and flush signals to the front end. Sits between the IF/ID register and the EX stage of the 32-bit pipelined core.

Parameters:
OP_W, 8, opcode width
REG_AW, 5, register address width
MUL_LAT, 3, MUL execute latency in cycles (>=1)
CNT_W, 16, perf counter width (used only with CTRL_PERF_EN)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  IF/ID holds a valid instruction
id_op  in  OP_W  opcode
id_rs1  in  REG_AW  source register 1
id_rs2  in  REG_AW  source register 2
id_rd  in  REG_AW  destination register
stall  out  1  hold PC and IF/ID this cycle
pc_src  out  1  jump taken (JAL accepted)
flush_if  out  1  squash IF/ID next edge
ex_hold  out  1  EX must keep current operation (MUL busy)
ex_alu_src  out  2  registered ALU B-source select
ex_alu_op  out  4  registered ALU operation
ex_mem_read  out  1  registered
ex_mem_write  out  1  registered
ex_mem_to_reg  out  2  registered writeback select
ex_reg_write  out  1  registered
ex_rd  out  REG_AW  registered destination
stall_cnt  out  CNT_W  stall cycles (CTRL_PERF_EN only)

Behaviour:
- Decode (combinational, default = NOP all-zero): ADD 0x08 reg_write=1; MUL 0x18 alu_op=0010, reg_write=1; ADDI 0x03 alu_src=01, mem_to_reg=01, reg_write=1; SW 0x19 mem_write=1, alu_src=01; LW 0x31 mem_read=1, mem_to_reg=01, reg_write=1, alu_src=01; JAL 0x04 mem_to_reg=10, reg_write=1, pc_src. Unknown opcode = NOP.
- rs2 used only by ADD, MUL, SW.
- Reset: all ex_* = 0, state IDLE, MUL counter 0, stall/pc_src/flush_if/ex_hold = 0, stall_cnt = 0. Reset mid-MUL aborts it with no pending writeback.
- FSM states IDLE, MUL_BUSY.
- IDLE, load-use: ex_mem_read=1, ex_rd!=0, and ex_rd equals id_rs1, or equals id_rs2 where rs2 is used. Response: stall=1; EX loaded with bubble (all zero); one cycle only.
- IDLE accept (id_valid, no hazard): EX loaded with decoded bundle next edge. id_valid=0 loads a bubble.
- Accepting MUL with MUL_LAT>1: counter = MUL_LAT-1, go MUL_BUSY.
- MUL_BUSY: stall=1, ex_hold=1, EX registers frozen, counter decrements. At counter==1 the next edge returns to IDLE. Total stall = MUL_LAT-1 cycles. MUL_LAT=1 never enters MUL_BUSY.
- JAL accepted (not stalled): pc_src=1 and flush_if=1 combinationally in the same cycle.
- Priority: MUL_BUSY > load-use > accept. A JAL in ID during any stall has no effect until accepted.
- ex_rd = id_rd for reg-writing ops, 0 otherwise.

Optional Feature:
CTRL_PERF_EN: when defined, stall_cnt increments every cycle stall=1 and saturates at all-ones; cleared by rst. When undefined, stall_cnt is tied to 0 and no counter flops are built.

Decomposition:
- Package ctrl_pkg holds: opcode localparams (OP_ADD, OP_MUL, OP_ADDI, OP_SW, OP_LW, OP_JAL), the ALU-op encodings, the typedef ctrl_bundle_t struct (alu_src, alu_op, mem_read, mem_write, mem_to_reg, reg_write) and the state enum.
- Sub-module ctrl_decode: purely combinational opcode-to-ctrl_bundle_t decoder plus the uses_rs2 flag, instantiated once. The FSM, hazard logic and ID/EX register stay in the top module.

Test Plan:
- rst asserted mid-operation -> all outputs 0 asynchronously, before the next clk edge.
- ADDI (op 0x03, rd=4) accepted -> next cycle ex_alu_src=01, ex_mem_to_reg=01, ex_reg_write=1, ex_rd=4; stall=0.
- LW rd=5, then ADD with rs2=5 -> one cycle stall=1, EX all-zero bubble, ADD issues the cycle after; repeat with rd=0 -> no stall.
- MUL with MUL_LAT=3 followed by ADD -> stall=1 and ex_hold=1 for exactly 2 cycles, ex_alu_op=0010 held, ADD enters EX on the 3rd cycle; repeat with MUL_LAT=1 -> no stall.
- JAL (0x04) accepted -> pc_src=1 and flush_if=1 the same cycle, ex_mem_to_reg=10 next cycle; JAL presented during a MUL stall -> pc_src=0 until accepted.
- With CTRL_PERF_EN, the LW-use case plus the MUL_LAT=3 case -> stall_cnt=3.
